// File: rtl/mdu_seq_if.sv
// Request/response bundle between an issuing pipeline and the sequential multiply/divide unit.
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, rs1, rs2, kill, input busy, done, result);
    modport slave  (input start, op, rs1, rs2, kill, output busy, done, result);
endinterface

// File: rtl/mdu_seq.sv
// Sequential RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MDU_EARLY_OUT_EN: zero-operand multiplies, divide-by-zero and signed overflow finish in one cycle.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input logic      clk,
    input logic      rst_n,
    mdu_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0]      OP_MUL    = 3'd0;
    localparam logic [2:0]      OP_MULH   = 3'd1;
    localparam logic [2:0]      OP_MULHSU = 3'd2;
    localparam logic [2:0]      OP_MULHU  = 3'd3;
    localparam logic [2:0]      OP_DIV    = 3'd4;
    localparam logic [2:0]      OP_DIVU   = 3'd5;
    localparam logic [2:0]      OP_REM    = 3'd6;
    localparam logic [2:0]      OP_REMU   = 3'd7;
    localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES      = {XLEN{1'b1}};
    localparam logic [5:0]      CNT_INIT  = 6'(XLEN - 1);

    state_t            state_r, state_nx_s;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   opb_r;      // multiplicand for multiplies, divisor for divides
    logic [2*XLEN-1:0] prod_r;
    logic [XLEN:0]     rem_r;
    logic [XLEN-1:0]   quo_r;
    logic [5:0]        cnt_r;
    logic              neg_res_r, neg_rem_r, div0_r;
    logic              busy_r, done_r;
    logic [XLEN-1:0]   result_r;

    logic              accept_s, is_div_s, sgn1_s, sgn2_s, neg1_s, neg2_s;
    logic [XLEN-1:0]   mag1_s, mag2_s;
    logic              early_s;
    logic [XLEN-1:0]   early_res_s;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN+1:0]   rem_sh_s, rem_sub_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s, rem_fix_s, fix_res_s;
    logic              busy_s, done_s;

    assign accept_s   = bus.start && !bus.kill && (state_r == IDLE || state_r == DONE);
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

    // Operand sign decode and magnitude conversion at the request boundary
    always_comb begin
        is_div_s = bus.op[2];
        sgn1_s   = 1'b0;
        sgn2_s   = 1'b0;
        case (bus.op)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn1_s = 1'b1;
                sgn2_s = 1'b1;
            end
            OP_MULHSU: begin
                sgn1_s = 1'b1;
                sgn2_s = 1'b0;
            end
            default: begin
                sgn1_s = 1'b0;
                sgn2_s = 1'b0;
            end
        endcase
        neg1_s = sgn1_s & bus.rs1[XLEN-1];
        neg2_s = sgn2_s & bus.rs2[XLEN-1];
        if (neg1_s) mag1_s = ZERO - bus.rs1;
        else        mag1_s = bus.rs1;
        if (neg2_s) mag2_s = ZERO - bus.rs2;
        else        mag2_s = bus.rs2;
    end

    // Short-circuit detection for trivially known results
    always_comb begin
        early_s     = 1'b0;
        early_res_s = ZERO;
`ifdef MDU_EARLY_OUT_EN
        if (is_div_s) begin
            if (bus.rs2 == ZERO) begin
                early_s = 1'b1;
                if (bus.op[1]) early_res_s = bus.rs1;
                else           early_res_s = ONES;
            end else if (!bus.op[0] && bus.rs1 == {1'b1, {(XLEN-1){1'b0}}} && bus.rs2 == ONES) begin
                early_s = 1'b1;
                if (bus.op[1]) early_res_s = ZERO;
                else           early_res_s = bus.rs1;
            end else begin
                early_s     = 1'b0;
                early_res_s = ZERO;
            end
        end else if (bus.rs1 == ZERO || bus.rs2 == ZERO) begin
            early_s     = 1'b1;
            early_res_s = ZERO;
        end else begin
            early_s     = 1'b0;
            early_res_s = ZERO;
        end
`endif
    end

    // Per-iteration datapath and final sign fix-up / result select
    always_comb begin
        if (prod_r[0]) mul_sum_s = {1'b0, prod_r[2*XLEN-1:XLEN]} + {1'b0, opb_r};
        else           mul_sum_s = {1'b0, prod_r[2*XLEN-1:XLEN]};
        rem_sh_s  = {rem_r, quo_r[XLEN-1]};
        rem_sub_s = rem_sh_s - {2'b00, opb_r};
        if (neg_res_r) prod_fix_s = {(2*XLEN){1'b0}} - prod_r;
        else           prod_fix_s = prod_r;
        // Divide by zero keeps an all-ones quotient regardless of dividend sign
        if (div0_r)         quo_fix_s = ONES;
        else if (neg_res_r) quo_fix_s = ZERO - quo_r;
        else                quo_fix_s = quo_r;
        if (neg_rem_r) rem_fix_s = ZERO - rem_r[XLEN-1:0];
        else           rem_fix_s = rem_r[XLEN-1:0];
        case (op_r)
            OP_MUL:                      fix_res_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_res_s = quo_fix_s;
            OP_REM, OP_REMU:             fix_res_s = rem_fix_s;
            default:                     fix_res_s = ZERO;
        endcase
    end

    // FSM state register and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // FSM next-state logic; kill always wins over start
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) state_nx_s = early_s ? DONE : CALC;
                else          state_nx_s = IDLE;
            end
            CALC: begin
                if (bus.kill)              state_nx_s = IDLE;
                else if (cnt_r == 6'd0)    state_nx_s = FIX;
                else                       state_nx_s = CALC;
            end
            FIX: begin
                if (bus.kill) state_nx_s = IDLE;
                else          state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM output decode, registered alongside the state
    always_comb begin
        busy_s = (state_nx_s == CALC) || (state_nx_s == FIX);
        done_s = (state_nx_s == DONE);
    end

    // Operand capture, one-bit iteration and result update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r      <= 3'd0;
            opb_r     <= ZERO;
            prod_r    <= {(2*XLEN){1'b0}};
            rem_r     <= {(XLEN+1){1'b0}};
            quo_r     <= ZERO;
            cnt_r     <= 6'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            result_r  <= ZERO;
        end else if (accept_s) begin
            op_r      <= bus.op;
            cnt_r     <= CNT_INIT;
            neg_res_r <= neg1_s ^ neg2_s;
            neg_rem_r <= neg1_s;
            div0_r    <= is_div_s && (bus.rs2 == ZERO);
            rem_r     <= {(XLEN+1){1'b0}};
            if (is_div_s) begin
                opb_r  <= mag2_s;
                quo_r  <= mag1_s;
                prod_r <= {(2*XLEN){1'b0}};
            end else begin
                opb_r  <= mag1_s;
                quo_r  <= ZERO;
                prod_r <= {ZERO, mag2_s};
            end
            if (early_s) result_r <= early_res_s;
            else         result_r <= result_r;
        end else if (state_r == CALC && !bus.kill) begin
            if (cnt_r != 6'd0) cnt_r <= cnt_r - 6'd1;
            else               cnt_r <= cnt_r;
            if (op_r[2]) begin
                quo_r <= {quo_r[XLEN-2:0], ~rem_sub_s[XLEN+1]};
                if (!rem_sub_s[XLEN+1]) rem_r <= rem_sub_s[XLEN:0];
                else                    rem_r <= rem_sh_s[XLEN:0];
            end else begin
                prod_r <= {mul_sum_s, prod_r[XLEN-1:1]};
            end
        end else if (state_r == FIX && !bus.kill) begin
            result_r <= fix_res_s;
        end else begin
            result_r <= result_r;
        end
    end
endmodule
